// File: rtl/serial_sub8_if.sv
// ============================================================================
// Module      : serial_sub8_if
// Description : Streaming port bundle for the byte-serial subtractor.
//               Optional Mode signal present when SERIAL_SUB_ADDMODE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_sub8_if;
    logic       start;
    logic       bin;
`ifdef SERIAL_SUB_ADDMODE_EN
    logic       mode;
`endif
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       last;
    logic       bout;
    logic       zero;
    logic       ovf;
    logic       busy;

    modport master (
        output start, bin,
`ifdef SERIAL_SUB_ADDMODE_EN
        output mode,
`endif
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, last, bout, zero, ovf, busy
    );

    modport slave (
        input  start, bin,
`ifdef SERIAL_SUB_ADDMODE_EN
        input  mode,
`endif
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, last, bout, zero, ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/serial_sub8.sv
// ============================================================================
// Module      : serial_sub8
// Description : Byte-serial WORDS-byte subtractor, LSB first, borrow chained
//               across beats. Define SERIAL_SUB_ADDMODE_EN for a Mode input
//               that selects addition instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub8 #(
    parameter int WORDS = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    serial_sub8_if.slave s
);

    localparam int             CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic          r_zacc;
    logic          r_out_valid;
    logic [7:0]    r_diff;
    logic          r_last;
    logic          r_bout;
    logic          r_zero;
    logic          r_ovf;
    logic          w_mode;

`ifdef SERIAL_SUB_ADDMODE_EN
    logic          r_mode;
    assign w_mode = r_mode;
`else
    assign w_mode = 1'b0;
`endif

    logic       w_in_ready;
    logic       w_xfer;
    logic [7:0] w_bop;
    logic       w_cin;
    logic [8:0] w_sum;
    logic [7:0] w_d;
    logic       w_chain;
    logic       w_ovf;
    logic       w_dzero;
    logic       w_final;

    assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || s.out_ready);
    assign w_xfer     = s.in_valid && w_in_ready;

    // Subtract is A + ~B + !borrow; add mode reuses the same adder with B and carry as-is.
    assign w_bop   = w_mode ? s.b : ~s.b;
    assign w_cin   = w_mode ? r_borrow : ~r_borrow;
    assign w_sum   = {1'b0, s.a} + {1'b0, w_bop} + {8'd0, w_cin};
    assign w_d     = w_sum[7:0];
    assign w_chain = w_mode ? w_sum[8] : ~w_sum[8];
    // Operands of equal effective sign producing a result of the other sign.
    assign w_ovf   = (s.a[7] == w_bop[7]) && (w_d[7] != s.a[7]);
    assign w_dzero = (w_d == 8'd0);
    assign w_final = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_zacc      <= 1'b0;
            r_out_valid <= 1'b0;
            r_diff      <= 8'd0;
            r_last      <= 1'b0;
            r_bout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
`ifdef SERIAL_SUB_ADDMODE_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s.start) begin
                        r_state  <= S_RUN;
                        r_borrow <= s.bin;
                        r_cnt    <= '0;
                        r_zacc   <= 1'b1;
`ifdef SERIAL_SUB_ADDMODE_EN
                        r_mode   <= s.mode;
`endif
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b1;
                        r_diff      <= w_d;
                        r_borrow    <= w_chain;
                        r_zacc      <= r_zacc && w_dzero;
                        if (w_final) begin
                            r_last  <= 1'b1;
                            r_bout  <= w_chain;
                            r_zero  <= r_zacc && w_dzero;
                            r_ovf   <= w_ovf;
                            r_state <= S_DRAIN;
                        end else begin
                            r_last  <= 1'b0;
                            r_bout  <= 1'b0;
                            r_zero  <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end else if (r_out_valid && s.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && s.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_last      <= 1'b0;
                        r_bout      <= 1'b0;
                        r_zero      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.diff      = r_diff;
    assign s.last      = r_last;
    assign s.bout      = r_bout;
    assign s.zero      = r_zero;
    assign s.ovf       = r_ovf;
    assign s.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_sub8.sv
// ============================================================================
// Module      : tb_serial_sub8
// Description : Scoreboard bench for serial_sub8 (WORDS=4) with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub8;

    logic clk;
    logic rst;
    serial_sub8_if sif ();

    serial_sub8 #(.WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .s   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic        mode;
        logic [31:0] d;
        logic        bout;
        logic        zero;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       bout;
        logic       zero;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every accepted output byte
    always @(negedge clk) begin
        if (!rst && sif.out_valid && sif.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h expected none", sif.diff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_byte", {20'd0, sif.diff, sif.last, sif.bout, sif.zero, sif.ovf},
                      {20'd0, e.d, e.last, e.bout, e.zero, e.ovf});
            end
        end
    end

    task automatic start_op(input vec_t v);
        @(posedge clk); #1;
        sif.start = 1'b1;
        sif.bin   = v.bin;
`ifdef SERIAL_SUB_ADDMODE_EN
        sif.mode  = v.mode;
`endif
        @(posedge clk); #1;
        sif.start = 1'b0;
        check("busy_after_start", {31'd0, sif.busy}, 32'd1);
    endtask

    // Feed nbeats bytes; stall = beat index after which OutReady is held low 3 cycles
    task automatic feed(input vec_t v, input int nbeats, input int stall);
        for (int i = 0; i < nbeats; i++) begin
            bit done;
            exp_t e;
            done = 1'b0;
            sif.a        = v.a[8*i +: 8];
            sif.b        = v.b[8*i +: 8];
            sif.in_valid = 1'b1;
            for (int t = 0; t < 20 && !done; t++) begin
                @(negedge clk);
                if (sif.in_ready) begin
                    e.d    = v.d[8*i +: 8];
                    e.last = (i == 3);
                    e.bout = (i == 3) ? v.bout : 1'b0;
                    e.zero = (i == 3) ? v.zero : 1'b0;
                    e.ovf  = (i == 3) ? v.ovf  : 1'b0;
                    sb.push_back(e);
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
            if (!done) check("in_ready_timeout", 32'd0, 32'd1);
            if (i == stall && i + 1 < nbeats) begin
                sif.out_ready = 1'b0;
                sif.start     = 1'b1;
                sif.a         = v.a[8*(i+1) +: 8];
                sif.b         = v.b[8*(i+1) +: 8];
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {31'd0, sif.in_ready}, 32'd0);
                    check("stall_diff_held", {23'd0, sif.out_valid, sif.diff},
                          {23'd0, 1'b1, v.d[8*i +: 8]});
                end
                @(posedge clk); #1;
                sif.out_ready = 1'b1;
                sif.start     = 1'b0;
            end
        end
        sif.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 10 && !idle; t++) begin
            @(negedge clk);
            if (!sif.busy) idle = 1'b1;
        end
        check("busy_drops", {31'd0, idle}, 32'd1);
        check("scoreboard_empty", sb.size(), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int stall);
        start_op(v);
        feed(v, 4, stall);
        wait_idle();
    endtask

    vec_t vecs[7];
    vec_t vstall;

    initial begin
        //            a             b             bin   mode  d             bout  zero  ovf
        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h00000100, 32'h00000001, 1'b0, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1};
        vstall  = '{32'h11223344, 32'h01020304, 1'b0, 1'b0, 32'h10203040, 1'b0, 1'b0, 1'b0};

        rst           = 1'b1;
        sif.start     = 1'b0;
        sif.bin       = 1'b0;
`ifdef SERIAL_SUB_ADDMODE_EN
        sif.mode      = 1'b0;
`endif
        sif.in_valid  = 1'b0;
        sif.a         = 8'd0;
        sif.b         = 8'd0;
        sif.out_ready = 1'b1;
        #12;
        check("reset_outputs",
              {18'd0, sif.out_valid, sif.in_ready, sif.busy, sif.diff, sif.last,
               sif.bout, sif.zero, sif.ovf}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], -1);

        // Backpressure after byte index 1 with a Start pulse during RUN
        run_vec(vstall, 1);

        // Asynchronous reset after two bytes have been accepted
        start_op(vecs[0]);
        feed(vecs[0], 2, -1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {22'd0, sif.out_valid, sif.busy, sif.diff}, 32'd0);
        check("rst_mid_sb_empty", sb.size(), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(vecs[0], -1);

`ifdef SERIAL_SUB_ADDMODE_EN
        begin
            vec_t va;
            va = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
            run_vec(va, -1);
            va = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1};
            run_vec(va, -1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/serial_sub8.md
Name: serial_sub8

Overview:
- Byte-serial multi-word subtractor: the subtract counterpart of the 8-bit carry-lookahead adder in the DSP datapath.
- Consumes two WORDS-byte operands one byte per beat, least-significant byte first.
- Propagates borrow across beats and emits difference bytes plus end-of-operation flags.
- Sits between the sample buffers and the accumulator/filter stages with valid/ready streaming.

Parameters:
WORDS, 4, bytes per operand (1..16); operand width = 8*WORDS bits.

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
Start  in  1  begin operation; sampled only in IDLE
Bin  in  1  initial borrow, latched with Start
InValid  in  1  A/B byte valid
InReady  out  1  block accepts A/B byte this cycle
A  in  8  minuend byte
B  in  8  subtrahend byte
OutValid  out  1  Diff valid
OutReady  in  1  downstream accepts Diff
Diff  out  8  difference byte
Last  out  1  marks the final (most-significant) Diff byte
Bout  out  1  final borrow; valid when OutValid&&Last
Zero  out  1  all WORDS Diff bytes zero; valid when OutValid&&Last
Ovf  out  1  signed overflow of the full-width subtract; valid when OutValid&&Last
Busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE. All outputs, the beat counter, the borrow register and the zero accumulator are 0, asynchronously.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on Start=1. Latch borrow=Bin, beat count=0, zero accumulator=1.
- Start is ignored in RUN and DRAIN.
- InReady = (state==RUN) && (!OutValid || OutReady).
- Input transfer occurs when InValid && InReady.
- Arithmetic per transfer: {c,D} = A + ~B + !borrow (9-bit). Diff<=D, borrow<=!c, OutValid<=1 on the next edge. Latency is 1 cycle.
- Output register holds Diff and flags stable while OutValid && !OutReady.
- OutValid clears on OutValid && OutReady unless a new transfer happens in the same cycle. Back-to-back accept and load is allowed, giving 1 beat/cycle throughput.
- Zero accumulator is ANDed with (D==0) on every transfer.
- Final beat (count==WORDS-1):
  - Last=1, Bout=!c, Zero=accumulator&&(D==0).
  - Ovf = (A[7]!=B[7]) && (D[7]!=A[7]).
  - State -> DRAIN.
- On non-final beats Last, Bout, Zero and Ovf are 0.
- DRAIN -> IDLE when the Last byte is accepted (OutValid&&OutReady). OutValid then drops and the flags clear.
- WORDS=1: the single beat is both first and last.
- Rst mid-operation: immediate return to IDLE and all outputs 0. The partial result is discarded and no Last is issued.
- Beat counter width is clog2(WORDS) with a minimum of 1 bit. It never wraps inside an operation.

Optional Feature:
Macro SERIAL_SUB_ADDMODE_EN.
- Defined:
  - Extra input port Mode (1 bit), latched with Start. Mode=1 computes A+B+carry; Bin acts as carry-in and Bout as final carry-out.
  - Ovf in add mode = (A[7]==B[7]) && (D[7]!=A[7]).
  - Mode=0 behaves exactly as the base subtractor.
- Undefined: no Mode port; subtraction only.

Test Plan:
1. WORDS=4, Bin=0, A=0x00000005, B=0x00000003, OutReady=1 -> Diff 02,00,00,00 on consecutive cycles; Last on the 4th byte; Bout=0, Zero=0, Ovf=0; Busy drops after the Last accept.
2. A=0x00000000, B=0x00000001 -> Diff FF,FF,FF,FF; Bout=1, Zero=0, Ovf=0.
3. A=0x12345678, B=0x12345678 -> Diff 00,00,00,00; Zero=1, Bout=0, Ovf=0. Repeat with Bin=1 -> FF x4, Bout=1, Zero=0.
4. A=0x80000000, B=0x00000001 -> Diff FF,FF,FF,7F; Ovf=1, Bout=0.
5. Backpressure: OutReady=0 for 3 cycles while byte 2 is valid -> InReady=0 and Diff held stable; no byte lost or duplicated. Start pulsed during RUN is ignored.
6. Rst pulsed after byte 2 accepted -> OutValid, Busy and Diff are 0 in the same cycle. A fresh Start with case 1 operands gives correct results.
